// File: rtl/buffer_transfer_splitter.sv
// Splits per-channel host buffers into TRANSFER_BYTES-bounded write requests with round-robin
// arbitration and per-channel ack tracking. Define LIBSTF_SPLITTER_STATS_EN to enable stat_reqs.
module buffer_transfer_splitter #(
    parameter int N_CHANNELS      = 4,
    parameter int TRANSFER_BYTES  = 65536,
    parameter int VADDR_W         = 48,
    parameter int SIZE_W          = 28,
    parameter int MAX_OUTSTANDING = 8,
    localparam int LEN_W          = $clog2(TRANSFER_BYTES) + 1,
    localparam int CH_W           = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_CHANNELS-1:0]         buf_valid,
    output logic [N_CHANNELS-1:0]         buf_ready,
    input  logic [N_CHANNELS*VADDR_W-1:0] buf_vaddr,
    input  logic [N_CHANNELS*SIZE_W-1:0]  buf_size,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [VADDR_W-1:0]            req_vaddr,
    output logic [LEN_W-1:0]              req_len,
    output logic [CH_W-1:0]               req_chan,
    output logic                          req_last,
    input  logic                          ack_valid,
    input  logic [CH_W-1:0]               ack_chan,
    output logic                          done_valid,
    input  logic                          done_ready,
    output logic [CH_W-1:0]               done_chan,
    output logic [SIZE_W-1:0]             done_bytes,
    output logic                          err_ack,
    output logic                          busy,
    output logic [31:0]                   stat_reqs
);

    localparam int OFF_W  = $clog2(TRANSFER_BYTES);
    localparam int CALC_W = SIZE_W + 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CALC_W-1:0] XFER_C    = CALC_W'(TRANSFER_BYTES);
    localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

    ch_state_e             state_r     [N_CHANNELS];
    ch_state_e             state_nxt_s [N_CHANNELS];
    logic [VADDR_W-1:0]    vaddr_r     [N_CHANNELS];
    logic [VADDR_W-1:0]    vaddr_nxt_s [N_CHANNELS];
    logic [SIZE_W-1:0]     rem_r       [N_CHANNELS];
    logic [SIZE_W-1:0]     rem_nxt_s   [N_CHANNELS];
    logic [SIZE_W-1:0]     size_r      [N_CHANNELS];
    logic [SIZE_W-1:0]     size_nxt_s  [N_CHANNELS];
    logic [OUT_W-1:0]      outst_r     [N_CHANNELS];
    logic [OUT_W-1:0]      outst_nxt_s [N_CHANNELS];
    logic [CALC_W-1:0]     room_s      [N_CHANNELS];
    logic [CALC_W-1:0]     chunk_s     [N_CHANNELS];

    logic [N_CHANNELS-1:0] last_s;
    logic [N_CHANNELS-1:0] elig_s;
    logic [N_CHANNELS-1:0] issue_s;
    logic [N_CHANNELS-1:0] ack_hit_s;
    logic [N_CHANNELS-1:0] done_cand_s;
    logic [N_CHANNELS-1:0] buf_ready_r;
    logic                  ack_err_s;
    logic                  busy_nxt_s;

    logic                  req_any_s;
    logic [CH_W-1:0]       req_gnt_s;
    logic                  req_load_s;
    logic [CH_W-1:0]       rr_req_r;
    logic                  done_any_s;
    logic [CH_W-1:0]       done_gnt_s;
    logic                  done_load_s;
    logic                  done_hs_s;
    logic [CH_W-1:0]       rr_done_r;

    logic                  req_valid_r;
    logic [VADDR_W-1:0]    req_vaddr_r;
    logic [LEN_W-1:0]      req_len_r;
    logic [CH_W-1:0]       req_chan_r;
    logic                  req_last_r;
    logic                  done_valid_r;
    logic [CH_W-1:0]       done_chan_r;
    logic [SIZE_W-1:0]     done_bytes_r;
    logic                  err_ack_r;
    logic                  busy_r;

    // Channel index base+off, wrapped into 0..N_CHANNELS-1 (off is at most N_CHANNELS-1).
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int sum_v;
        sum_v = int'(base) + off;
        if (sum_v >= N_CHANNELS) begin
            sum_v = sum_v - N_CHANNELS;
        end else begin
            sum_v = sum_v;
        end
        return CH_W'(sum_v);
    endfunction

    // Chunk size per channel: remaining bytes clipped to the distance to the next aligned boundary.
    always_comb begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            room_s[c]      = XFER_C - CALC_W'(vaddr_r[c][OFF_W-1:0]);
            chunk_s[c]     = ({1'b0, rem_r[c]} < room_s[c]) ? {1'b0, rem_r[c]} : room_s[c];
            last_s[c]      = (chunk_s[c] == {1'b0, rem_r[c]});
            elig_s[c]      = (state_r[c] == ST_SPLIT) && (outst_r[c] < MAX_OUT_C);
            ack_hit_s[c]   = ack_valid && (ack_chan == CH_W'(c)) && (outst_r[c] != '0);
            done_cand_s[c] = ((state_r[c] == ST_DRAIN) && (outst_r[c] == '0)) ||
                             ((state_r[c] == ST_DONE) &&
                              !(done_valid_r && (done_chan_r == CH_W'(c))));
        end
        ack_err_s = ack_valid && !(|ack_hit_s);
    end

    // Round-robin selection for the request and completion ports.
    always_comb begin
        req_any_s  = 1'b0;
        req_gnt_s  = '0;
        done_any_s = 1'b0;
        done_gnt_s = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (!req_any_s && elig_s[rr_idx(rr_req_r, i)]) begin
                req_any_s = 1'b1;
                req_gnt_s = rr_idx(rr_req_r, i);
            end else begin
                req_gnt_s = req_gnt_s;
            end
            if (!done_any_s && done_cand_s[rr_idx(rr_done_r, i)]) begin
                done_any_s = 1'b1;
                done_gnt_s = rr_idx(rr_done_r, i);
            end else begin
                done_gnt_s = done_gnt_s;
            end
        end
        req_load_s  = !req_valid_r || req_ready;
        done_load_s = !done_valid_r || done_ready;
        done_hs_s   = done_valid_r && done_ready;
        for (int c = 0; c < N_CHANNELS; c++) begin
            issue_s[c] = req_load_s && req_any_s && (req_gnt_s == CH_W'(c));
        end
    end

    // Per-channel next state, address, remaining size and outstanding count.
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            state_nxt_s[c] = state_r[c];
            vaddr_nxt_s[c] = vaddr_r[c];
            rem_nxt_s[c]   = rem_r[c];
            size_nxt_s[c]  = size_r[c];
            case (state_r[c])
                ST_IDLE: begin
                    if (buf_valid[c] && buf_ready_r[c]) begin
                        vaddr_nxt_s[c] = buf_vaddr[c*VADDR_W +: VADDR_W];
                        rem_nxt_s[c]   = buf_size[c*SIZE_W +: SIZE_W];
                        size_nxt_s[c]  = buf_size[c*SIZE_W +: SIZE_W];
                        state_nxt_s[c] = (buf_size[c*SIZE_W +: SIZE_W] == '0) ? ST_DONE : ST_SPLIT;
                    end else begin
                        state_nxt_s[c] = ST_IDLE;
                    end
                end
                ST_SPLIT: begin
                    if (issue_s[c]) begin
                        vaddr_nxt_s[c] = vaddr_r[c] + VADDR_W'(chunk_s[c]);
                        rem_nxt_s[c]   = rem_r[c] - chunk_s[c][SIZE_W-1:0];
                        state_nxt_s[c] = last_s[c] ? ST_DRAIN : ST_SPLIT;
                    end else begin
                        state_nxt_s[c] = ST_SPLIT;
                    end
                end
                ST_DRAIN: begin
                    if (outst_r[c] == '0) begin
                        state_nxt_s[c] = ST_DONE;
                    end else begin
                        state_nxt_s[c] = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (done_hs_s && (done_chan_r == CH_W'(c))) begin
                        state_nxt_s[c] = ST_IDLE;
                    end else begin
                        state_nxt_s[c] = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s[c] = ST_IDLE;
                end
            endcase
            // An issue and an ack in the same cycle cancel out.
            case ({issue_s[c], ack_hit_s[c]})
                2'b10:   outst_nxt_s[c] = outst_r[c] + OUT_W'(1);
                2'b01:   outst_nxt_s[c] = outst_r[c] - OUT_W'(1);
                default: outst_nxt_s[c] = outst_r[c];
            endcase
            if (state_nxt_s[c] != ST_IDLE) begin
                busy_nxt_s = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                state_r[c] <= ST_IDLE;
                vaddr_r[c] <= '0;
                rem_r[c]   <= '0;
                size_r[c]  <= '0;
                outst_r[c] <= '0;
            end
            buf_ready_r <= '0;
            busy_r      <= 1'b0;
            err_ack_r   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                state_r[c]     <= state_nxt_s[c];
                vaddr_r[c]     <= vaddr_nxt_s[c];
                rem_r[c]       <= rem_nxt_s[c];
                size_r[c]      <= size_nxt_s[c];
                outst_r[c]     <= outst_nxt_s[c];
                buf_ready_r[c] <= (state_nxt_s[c] == ST_IDLE);
            end
            busy_r    <= busy_nxt_s;
            err_ack_r <= err_ack_r | ack_err_s;
        end
    end

    // Request and completion output registers; reloaded only when empty or accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_valid_r  <= 1'b0;
            req_vaddr_r  <= '0;
            req_len_r    <= '0;
            req_chan_r   <= '0;
            req_last_r   <= 1'b0;
            rr_req_r     <= '0;
            done_valid_r <= 1'b0;
            done_chan_r  <= '0;
            done_bytes_r <= '0;
            rr_done_r    <= '0;
        end else begin
            if (req_load_s) begin
                req_valid_r <= req_any_s;
                if (req_any_s) begin
                    req_vaddr_r <= vaddr_r[req_gnt_s];
                    req_len_r   <= LEN_W'(chunk_s[req_gnt_s]);
                    req_chan_r  <= req_gnt_s;
                    req_last_r  <= last_s[req_gnt_s];
                    rr_req_r    <= rr_idx(req_gnt_s, 1);
                end
            end
            if (done_load_s) begin
                done_valid_r <= done_any_s;
                if (done_any_s) begin
                    done_chan_r  <= done_gnt_s;
                    done_bytes_r <= size_r[done_gnt_s];
                    rr_done_r    <= rr_idx(done_gnt_s, 1);
                end
            end
        end
    end

`ifdef LIBSTF_SPLITTER_STATS_EN
    logic [31:0] stat_reqs_r;

    // Free-running count of accepted request handshakes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_reqs_r <= 32'd0;
        end else if (req_valid_r && req_ready) begin
            stat_reqs_r <= stat_reqs_r + 32'd1;
        end
    end

    assign stat_reqs = stat_reqs_r;
`else
    assign stat_reqs = 32'd0;
`endif

    assign buf_ready  = buf_ready_r;
    assign req_valid  = req_valid_r;
    assign req_vaddr  = req_vaddr_r;
    assign req_len    = req_len_r;
    assign req_chan   = req_chan_r;
    assign req_last   = req_last_r;
    assign done_valid = done_valid_r;
    assign done_chan  = done_chan_r;
    assign done_bytes = done_bytes_r;
    assign err_ack    = err_ack_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_buffer_transfer_splitter.sv
// Directed self-checking bench for buffer_transfer_splitter (4 channels, 4 KiB transfers, window 2).
module tb_buffer_transfer_splitter;

    logic         aclk;
    logic         aresetn;
    logic [3:0]   buf_valid;
    logic [3:0]   buf_ready;
    logic [191:0] buf_vaddr;
    logic [111:0] buf_size;
    logic         req_valid;
    logic         req_ready;
    logic [47:0]  req_vaddr;
    logic [12:0]  req_len;
    logic [1:0]   req_chan;
    logic         req_last;
    logic         ack_valid;
    logic [1:0]   ack_chan;
    logic         done_valid;
    logic         done_ready;
    logic [1:0]   done_chan;
    logic [27:0]  done_bytes;
    logic         err_ack;
    logic         busy;
    logic [31:0]  stat_reqs;

    int checks;
    int failures;

    logic [47:0] rq_vaddr [$];
    logic [12:0] rq_len   [$];
    logic [1:0]  rq_chan  [$];
    logic        rq_last  [$];
    logic [1:0]  dn_chan  [$];
    logic [27:0] dn_bytes [$];
    int          last_ack_cyc;
    int          first_done_cyc;

    buffer_transfer_splitter #(
        .N_CHANNELS(4),
        .TRANSFER_BYTES(4096),
        .VADDR_W(48),
        .SIZE_W(28),
        .MAX_OUTSTANDING(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .buf_valid(buf_valid), .buf_ready(buf_ready),
        .buf_vaddr(buf_vaddr), .buf_size(buf_size),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_len(req_len),
        .req_chan(req_chan), .req_last(req_last),
        .ack_valid(ack_valid), .ack_chan(ack_chan),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_chan(done_chan), .done_bytes(done_bytes),
        .err_ack(err_ack), .busy(busy), .stat_reqs(stat_reqs)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn    = 1'b0;
        buf_valid  = 4'h0;
        buf_vaddr  = '0;
        buf_size   = '0;
        req_ready  = 1'b0;
        ack_valid  = 1'b0;
        ack_chan   = 2'd0;
        done_ready = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic set_buf(input int ch, input logic [47:0] va, input logic [27:0] sz);
        buf_vaddr[ch*48 +: 48] = va;
        buf_size[ch*28 +: 28]  = sz;
    endtask

    // Runs the bus for a fixed number of cycles, recording requests/completions and
    // optionally acknowledging each accepted request on the following cycle.
    task automatic run_traffic(input int cycles, input bit auto_ack);
        bit         pend;
        bit         pend_last;
        logic [1:0] pend_ch;
        pend = 1'b0;
        pend_last = 1'b0;
        pend_ch = 2'd0;
        rq_vaddr.delete(); rq_len.delete(); rq_chan.delete(); rq_last.delete();
        dn_chan.delete(); dn_bytes.delete();
        last_ack_cyc = -1;
        first_done_cyc = -1;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            ack_valid = pend;
            ack_chan  = pend_ch;
            if (pend && pend_last) last_ack_cyc = cyc;
            pend = 1'b0;
            if (req_valid && req_ready) begin
                rq_vaddr.push_back(req_vaddr);
                rq_len.push_back(req_len);
                rq_chan.push_back(req_chan);
                rq_last.push_back(req_last);
                if (auto_ack) begin
                    pend = 1'b1;
                    pend_ch = req_chan;
                    pend_last = req_last;
                end
            end
            if (done_valid && done_ready) begin
                dn_chan.push_back(done_chan);
                dn_bytes.push_back(done_bytes);
                if (first_done_cyc < 0) first_done_cyc = cyc;
            end
            step();
        end
        ack_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        buf_valid = 4'h0; buf_vaddr = '0; buf_size = '0;
        req_ready = 1'b0; ack_valid = 1'b0; ack_chan = 2'd0; done_ready = 1'b0;
        step();
        checks++;
        if (buf_ready !== 4'h0) begin
            failures++; $display("FAIL reset_buf_ready: got %h expected 0", buf_ready);
        end
        checks++;
        if ({req_valid, done_valid, err_ack, busy} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b expected 0000", {req_valid, done_valid, err_ack, busy});
        end
        checks++;
        if ({req_vaddr, req_len, req_chan, req_last, done_chan, done_bytes, stat_reqs} !== '0) begin
            failures++; $display("FAIL reset_data: req_vaddr=%h req_len=%0d done_bytes=%0d stat=%0d expected all 0",
                                 req_vaddr, req_len, done_bytes, stat_reqs);
        end
        aresetn = 1'b1;
        step();
        checks++;
        if (buf_ready !== 4'hF) begin
            failures++; $display("FAIL reset_release_ready: got %h expected f", buf_ready);
        end
    endtask

    task automatic test_split();
        logic [47:0] exp_va [3];
        logic [12:0] exp_len [3];
        logic        exp_last [3];
        logic [31:0] exp_stat;
        exp_va[0] = 48'h0000_1000_0800; exp_len[0] = 13'd2048; exp_last[0] = 1'b0;
        exp_va[1] = 48'h0000_1000_1000; exp_len[1] = 13'd4096; exp_last[1] = 1'b0;
        exp_va[2] = 48'h0000_1000_2000; exp_len[2] = 13'd3856; exp_last[2] = 1'b1;
`ifdef LIBSTF_SPLITTER_STATS_EN
        exp_stat = 32'd3;
`else
        exp_stat = 32'd0;
`endif
        do_reset();
        req_ready = 1'b1;
        done_ready = 1'b1;
        set_buf(0, 48'h0000_1000_0800, 28'd10000);
        buf_valid = 4'b0001;
        step();
        buf_valid = 4'h0;
        checks++;
        if (req_valid !== 1'b0) begin
            failures++; $display("FAIL split_early_req: req_valid=%b expected 0 one cycle after accept", req_valid);
        end
        step();
        checks++;
        if (req_valid !== 1'b1) begin
            failures++; $display("FAIL split_latency: req_valid=%b expected 1 two cycles after accept", req_valid);
        end
        run_traffic(60, 1'b1);
        checks++;
        if (rq_vaddr.size() != 3) begin
            failures++; $display("FAIL split_count: got %0d requests expected 3", rq_vaddr.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rq_vaddr.size()) begin
                failures++; $display("FAIL split_req%0d: missing request", i);
            end else if ({rq_vaddr[i], rq_len[i], rq_chan[i], rq_last[i]} !==
                         {exp_va[i], exp_len[i], 2'd0, exp_last[i]}) begin
                failures++;
                $display("FAIL split_req%0d: got va=%h len=%0d ch=%0d last=%b expected va=%h len=%0d ch=0 last=%b",
                         i, rq_vaddr[i], rq_len[i], rq_chan[i], rq_last[i], exp_va[i], exp_len[i], exp_last[i]);
            end
        end
        checks++;
        if (dn_chan.size() != 1 || dn_chan[0] !== 2'd0 || dn_bytes[0] !== 28'd10000) begin
            failures++; $display("FAIL split_done: count=%0d expected one completion ch 0 bytes 10000", dn_chan.size());
        end
        checks++;
        if (first_done_cyc - last_ack_cyc != 2) begin
            failures++; $display("FAIL split_done_latency: got %0d cycles expected 2", first_done_cyc - last_ack_cyc);
        end
        checks++;
        if (stat_reqs !== exp_stat) begin
            failures++; $display("FAIL split_stat: got %0d expected %0d", stat_reqs, exp_stat);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL split_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_zero_size();
        int  found_at;
        bit  req_seen;
        logic [1:0]  got_ch;
        logic [27:0] got_bytes;
        found_at = -1; req_seen = 1'b0; got_ch = 2'd0; got_bytes = '0;
        do_reset();
        req_ready = 1'b1;
        done_ready = 1'b1;
        set_buf(2, 48'h0000_0000_1234, 28'd0);
        buf_valid = 4'b0100;
        step();
        buf_valid = 4'h0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (req_valid) req_seen = 1'b1;
            if (done_valid && found_at < 0) begin
                found_at = cyc; got_ch = done_chan; got_bytes = done_bytes;
            end
            step();
        end
        checks++;
        if (found_at < 0 || found_at > 2) begin
            failures++; $display("FAIL zero_done_latency: done seen at %0d expected within 3 cycles of accept", found_at);
        end
        checks++;
        if ({got_ch, got_bytes} !== {2'd2, 28'd0}) begin
            failures++; $display("FAIL zero_done_fields: got ch=%0d bytes=%0d expected ch=2 bytes=0", got_ch, got_bytes);
        end
        checks++;
        if (req_seen !== 1'b0) begin
            failures++; $display("FAIL zero_no_request: req_valid seen=%b expected 0", req_seen);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] seq;
        logic [3:0]  done_mask;
        seq = '0; done_mask = '0;
        do_reset();
        req_ready = 1'b1;
        done_ready = 1'b1;
        for (int c = 0; c < 4; c++) set_buf(c, 48'(c) << 16, 28'd8192);
        buf_valid = 4'hF;
        step();
        buf_valid = 4'h0;
        run_traffic(80, 1'b1);
        for (int i = 0; i < rq_chan.size() && i < 8; i++) seq = {seq[13:0], rq_chan[i]};
        for (int i = 0; i < dn_chan.size(); i++) done_mask[dn_chan[i]] = 1'b1;
        checks++;
        if (rq_chan.size() != 8) begin
            failures++; $display("FAIL rr_count: got %0d requests expected 8", rq_chan.size());
        end
        checks++;
        if (seq !== 16'h1B1B) begin
            failures++; $display("FAIL rr_sequence: got %h expected 1b1b (0,1,2,3,0,1,2,3)", seq);
        end
        checks++;
        if (rq_vaddr.size() < 5) begin
            failures++; $display("FAIL rr_fifth_req: missing request");
        end else if ({rq_vaddr[4], rq_len[4], rq_last[4]} !== {48'h0000_0000_1000, 13'd4096, 1'b1}) begin
            failures++; $display("FAIL rr_fifth_req: got va=%h len=%0d last=%b expected va=1000 len=4096 last=1",
                                 rq_vaddr[4], rq_len[4], rq_last[4]);
        end
        checks++;
        if (dn_chan.size() != 4 || done_mask !== 4'hF) begin
            failures++; $display("FAIL rr_done: got %0d completions mask %h expected 4 mask f", dn_chan.size(), done_mask);
        end
    endtask

    task automatic test_window();
        int cnt0;
        int cnt1;
        do_reset();
        req_ready = 1'b1;
        done_ready = 1'b1;
        set_buf(0, 48'h0000_0000_0000, 28'd16384);
        set_buf(1, 48'h0000_0010_0000, 28'd16384);
        buf_valid = 4'b0011;
        step();
        buf_valid = 4'h0;
        run_traffic(20, 1'b0);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < rq_chan.size(); i++) begin
            if (rq_chan[i] == 2'd0) cnt0++;
            if (rq_chan[i] == 2'd1) cnt1++;
        end
        checks++;
        if (cnt0 != 2 || cnt1 != 2) begin
            failures++; $display("FAIL window_fill: got ch0=%0d ch1=%0d expected 2 and 2", cnt0, cnt1);
        end
        checks++;
        if (req_valid !== 1'b0) begin
            failures++; $display("FAIL window_stall: req_valid=%b expected 0", req_valid);
        end
        ack_valid = 1'b1;
        ack_chan = 2'd1;
        step();
        ack_valid = 1'b0;
        run_traffic(20, 1'b0);
        checks++;
        if (rq_chan.size() != 1 || rq_chan[0] !== 2'd1) begin
            failures++; $display("FAIL window_one_more: got %0d requests expected exactly one on ch1", rq_chan.size());
        end
        checks++;
        if (err_ack !== 1'b0) begin
            failures++; $display("FAIL window_err: err_ack=%b expected 0", err_ack);
        end
    endtask

    task automatic test_err_ack();
        do_reset();
        checks++;
        if (err_ack !== 1'b0) begin
            failures++; $display("FAIL err_initial: err_ack=%b expected 0", err_ack);
        end
        ack_valid = 1'b1;
        ack_chan = 2'd1;
        step();
        ack_valid = 1'b0;
        checks++;
        if (err_ack !== 1'b1) begin
            failures++; $display("FAIL err_set: err_ack=%b expected 1", err_ack);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (err_ack !== 1'b1) begin
            failures++; $display("FAIL err_held: err_ack=%b expected 1", err_ack);
        end
        req_ready = 1'b1;
        done_ready = 1'b1;
        set_buf(0, 48'h0000_3000_0000, 28'd5000);
        buf_valid = 4'b0001;
        step();
        buf_valid = 4'h0;
        run_traffic(40, 1'b1);
        checks++;
        if (rq_len.size() != 2 || rq_len[0] !== 13'd4096 || rq_len[1] !== 13'd904 || rq_last[1] !== 1'b1) begin
            failures++; $display("FAIL err_other_chan_reqs: got %0d requests expected lens 4096,904(last)", rq_len.size());
        end
        checks++;
        if (dn_chan.size() != 1 || dn_chan[0] !== 2'd0 || dn_bytes[0] !== 28'd5000) begin
            failures++; $display("FAIL err_other_chan_done: got %0d completions expected ch0 bytes 5000", dn_chan.size());
        end
        checks++;
        if (err_ack !== 1'b1) begin
            failures++; $display("FAIL err_still_held: err_ack=%b expected 1", err_ack);
        end
    endtask

    task automatic test_stall_and_reset();
        int seen;
        do_reset();
        req_ready = 1'b0;
        done_ready = 1'b1;
        set_buf(0, 48'h0000_2000_0100, 28'd9000);
        buf_valid = 4'b0001;
        step();
        buf_valid = 4'h0;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({req_valid, req_vaddr, req_len, req_chan, req_last} !==
                {1'b1, 48'h0000_2000_0100, 13'd3840, 2'd0, 1'b0}) begin
                failures++; $display("FAIL stall_stable_%0d: got v=%b va=%h len=%0d expected v=1 va=20000100 len=3840",
                                     i, req_valid, req_vaddr, req_len);
            end
            step();
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        checks++;
        if ({req_valid, req_vaddr, req_len, req_last} !== {1'b1, 48'h0000_2000_1000, 13'd4096, 1'b0}) begin
            failures++; $display("FAIL stall_next_req: got v=%b va=%h len=%0d expected v=1 va=20001000 len=4096",
                                 req_valid, req_vaddr, req_len);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({req_valid, done_valid, busy, buf_ready, req_vaddr, req_len} !== '0) begin
            failures++; $display("FAIL midreset_outputs: v=%b busy=%b ready=%h va=%h expected all 0",
                                 req_valid, busy, buf_ready, req_vaddr);
        end
        step();
        aresetn = 1'b1;
        step();
        checks++;
        if (buf_ready !== 4'hF) begin
            failures++; $display("FAIL midreset_ready: got %h expected f", buf_ready);
        end
        req_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid || done_valid || busy) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL midreset_no_replay: activity in %0d cycles expected 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_split();
        test_zero_size();
        test_round_robin();
        test_window();
        test_err_ack();
        test_stall_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_transfer_splitter.md
# buffer_transfer_splitter

Multi-channel transfer splitter between the per-stream host buffer descriptors (virtual address + allocation size) and the Coyote write-request path. It accepts one host buffer per channel, cuts it into requests of at most `TRANSFER_BYTES` that never cross a `TRANSFER_BYTES`-aligned boundary, and arbitrates round-robin across channels. It tracks outstanding acknowledgements per channel and emits one completion per buffer once every request is acknowledged. It generalises the fixed single-stream transfer sizing to N channels with a configurable size and outstanding window.

## Interface
Parameters:
- `N_CHANNELS`, 4: independent buffer channels, ≥1.
- `TRANSFER_BYTES`, 65536: maximum and alignment of one request; power of two.
- `VADDR_W`, 48: virtual address width.
- `SIZE_W`, 28: buffer size width, giving a max buffer of 2^28−1 bytes.
- `MAX_OUTSTANDING`, 8: unacknowledged requests allowed per channel, ≥1.
- `LEN_W` (derived): log2(`TRANSFER_BYTES`)+1.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `buf_valid` / `buf_ready` in/out N_CHANNELS: per-channel descriptor handshake.
- `buf_vaddr` in N_CHANNELS*VADDR_W: start address, channel c at [c*VADDR_W +: VADDR_W].
- `buf_size` in N_CHANNELS*SIZE_W: buffer size in bytes.
- `req_valid` / `req_ready` out/in 1: request handshake.
- `req_vaddr` out VADDR_W: request address.
- `req_len` out LEN_W: request length in bytes, 1..`TRANSFER_BYTES`.
- `req_chan` out log2(N_CHANNELS) (min 1): issuing channel.
- `req_last` out 1: final request of the buffer.
- `ack_valid` in 1: single-cycle acknowledgement pulse.
- `ack_chan` in log2(N_CHANNELS): channel acknowledged.
- `done_valid` / `done_ready` out/in 1: completion handshake.
- `done_chan` out log2(N_CHANNELS): completed channel.
- `done_bytes` out SIZE_W: bytes written, equal to the buffer size.
- `err_ack` out 1: sticky flag for an unexpected ack.
- `busy` out 1: any channel not IDLE.
- `stat_reqs` out 32: see Configuration.

## Operation
- Per-channel FSM: IDLE → SPLIT → DRAIN → DONE → IDLE.
  - `buf_ready[c]`=1 only in IDLE. A handshake latches vaddr/size and enters SPLIT; a size of 0 enters DONE directly.
  - SPLIT: the channel is eligible when its outstanding count < `MAX_OUTSTANDING`.
    - Chunk = min(remaining, `TRANSFER_BYTES` − (vaddr mod `TRANSFER_BYTES`)).
    - On issue: vaddr += chunk, remaining −= chunk, outstanding += 1. When remaining reaches 0 the request carries `req_last`=1 and the channel enters DRAIN.
  - DRAIN: waits for outstanding == 0, then enters DONE.
  - DONE: competes for the done port (round-robin, separate pointer); on handshake returns to IDLE.
- Request arbiter: round-robin, with the pointer advancing to the channel after the granted one. The output register is loaded only when empty or on `req_ready`.
- Acks:
  - `ack_valid` decrements outstanding[`ack_chan`].
  - An ack to a channel with outstanding 0, or an out-of-range channel, is dropped and sets `err_ack` until reset.
  - A simultaneous issue and ack on the same channel leave the count unchanged.
- Arithmetic: the chunk calculation is unsigned, performed at SIZE_W+1 bits, and cannot underflow. vaddr wraps modulo 2^VADDR_W.

## Timing
- Reset values: `buf_ready`=0 during reset, all 1 from the first cycle after deassertion. `req_valid`, `done_valid`, `err_ack`, `busy` and `stat_reqs` are 0; all data outputs are 0; arbiter pointers are at 0.
- Latency:
  - Buffer accepted in cycle T → earliest `req_valid` at T+2.
  - Back-to-back requests issue one per cycle while `req_ready`=1.
  - Final ack in cycle T → `done_valid` at T+2 (counter update at T+1, DONE at T+2).
- `req_*` and `done_*` stay stable while `valid`=1 and `ready`=0; `valid` never drops without a handshake.
- Reset mid-operation clears all state; no requests or completions are replayed.

## Configuration
- `LIBSTF_SPLITTER_STATS_EN` defined: `stat_reqs` is a free-running 32-bit count of accepted request handshakes that wraps at 2^32.
- Not defined: `stat_reqs` is tied to 0 and the counter is not synthesised; the port stays present.

## Test plan
- `TRANSFER_BYTES`=4096, ch0 vaddr 0x1000_0800 size 10000, `req_ready`=1, immediate acks → three requests:
  - 0x1000_0800 len 2048;
  - 0x1000_1000 len 4096;
  - 0x1000_2000 len 3856 with `req_last`.
  - Then done ch0 with `done_bytes`=10000.
- Size 0 on ch2 → no request; `done_valid` with chan 2 and bytes 0 within 3 cycles.
- All 4 channels loaded with 8192 bytes aligned, `req_ready`=1 → `req_chan` sequence 0,1,2,3,0,1,2,3.
- `MAX_OUTSTANDING`=2 with acks withheld → exactly 2 requests per channel, then a stall. One ack → exactly one more request.
- Ack to idle ch1 → `err_ack`=1 and held; other channels unaffected.
- `req_ready`=0 for 10 cycles mid-buffer → outputs stable. Reset asserted mid-buffer → all outputs return to reset values and `buf_ready`=all-1 afterwards.
